// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default address width and Gray/binary conversions.
// Conversions work on a wide word; callers zero-extend in and truncate out.
package fifo_pkg;

    localparam int FIFO_AW   = 4;
    localparam int GRAY_MAXW = 32;

    typedef logic [GRAY_MAXW-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits stay zero, so any width up to GRAY_MAXW is exact.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW-2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/almost-full generation for an async Gray FIFO.
// Flags are computed from the next pointer and registered, so they are pessimistic by one cycle.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int AW       = FIFO_AW,
    parameter int AFULL_TH = 2**AW - 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WINC,
    input  logic [AW:0]   RPTR_SYNC,
    output logic          WPUSH,
    output logic [AW-1:0] WADDR,
    output logic [AW:0]   WPTR,
    output logic          WFULL,
    output logic          AFULL,
    output logic [AW:0]   WLEVEL,
    output logic          OVERFLOW
);

    localparam logic [AW:0] AFULL_TH_W = (AW+1)'(AFULL_TH);

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] rptr_full_cmp;
    logic [AW:0] wlevel_next;
    logic        wfull_next;
    logic        afull_next;

    // Gating on the registered WFULL means a read seen this cycle only frees space next cycle.
    assign WPUSH = WINC & ~WFULL & ~RST;
    assign WADDR = wbin[AW-1:0];

    always_comb begin
        wbin_next     = wbin + {{AW{1'b0}}, WPUSH};
        wgray_next    = (AW+1)'(bin2gray(gray_word_t'(wbin_next)));
        rbin          = (AW+1)'(gray2bin(gray_word_t'(RPTR_SYNC)));
        // Full when write pointer is one lap ahead: top two Gray bits inverted.
        rptr_full_cmp = {~RPTR_SYNC[AW:AW-1], RPTR_SYNC[AW-2:0]};
        wfull_next    = (wgray_next == rptr_full_cmp);
        wlevel_next   = wbin_next - rbin;
        afull_next    = (wlevel_next >= AFULL_TH_W);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wbin     <= '0;
            WPTR     <= '0;
            WFULL    <= 1'b0;
            AFULL    <= 1'b0;
            WLEVEL   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            WPTR   <= wgray_next;
            WFULL  <= wfull_next;
            AFULL  <= afull_next;
            WLEVEL <= wlevel_next;
            if (WINC && WFULL)
                OVERFLOW <= 1'b1;
        end
    end

endmodule
